// File: rtl/daq_capture_sequencer_if.sv
// Signal bundle between the capture sequencer and its trigger/ADC/buffer/packetizer neighbours.
// master = sequencer side, slave = surrounding environment.
interface daq_capture_sequencer_if #(
  parameter int unsigned HOLDOFF_W = 16,
  parameter int unsigned MISS_W    = 8
);
  logic                 arm_en;
  logic                 single_shot;
  logic                 trigger_in;
  logic                 adc_valid;
  logic [7:0]           capture_len_cfg;
  logic [HOLDOFF_W-1:0] holdoff_cfg;
  logic [31:0]          timestamp_counter;
  logic                 frame_done;

  logic                 sample_we;
  logic [7:0]           sample_idx;
  logic                 frame_start;
  logic [31:0]          frame_ts;
  logic [7:0]           frame_len;
  logic                 busy;
  logic [2:0]           state_o;
  logic [MISS_W-1:0]    missed_trig_cnt;
  logic                 err_len_zero;

  modport master (
    input  arm_en, single_shot, trigger_in, adc_valid, capture_len_cfg,
           holdoff_cfg, timestamp_counter, frame_done,
    output sample_we, sample_idx, frame_start, frame_ts, frame_len, busy,
           state_o, missed_trig_cnt, err_len_zero
  );

  modport slave (
    output arm_en, single_shot, trigger_in, adc_valid, capture_len_cfg,
           holdoff_cfg, timestamp_counter, frame_done,
    input  sample_we, sample_idx, frame_start, frame_ts, frame_len, busy,
           state_o, missed_trig_cnt, err_len_zero
  );
endinterface

// File: rtl/daq_capture_sequencer.sv
// Sequences one acquisition frame at a time: arm, trigger, gate N samples,
// hand off to the packetizer, wait for transmission, holdoff, re-arm.
module daq_capture_sequencer #(
  parameter int unsigned HOLDOFF_W = 16,
  parameter int unsigned MISS_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  daq_capture_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 trig_q;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           len_q, len_d;
  logic [31:0]          ts_q, ts_d;
  logic [HOLDOFF_W-1:0] hold_q, hold_d;
  logic [MISS_W-1:0]    miss_q, miss_d;
  logic                 err_q, err_d;
  logic                 fs_q, fs_d;

  logic                 trig_edge;
  logic                 miss_inc;
  logic                 we_c;
  state_e               exit_state;

  // State and frame-context registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      ts_q    <= '0;
      hold_q  <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= bus.trigger_in;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ts_q    <= ts_d;
      hold_q  <= hold_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      fs_q    <= fs_d;
    end
  end

  // Next-state and frame bookkeeping
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ts_d       = ts_q;
    hold_d     = hold_q;
    err_d      = err_q;
    fs_d       = 1'b0;
    miss_inc   = 1'b0;
    trig_edge  = bus.trigger_in & ~trig_q;
    we_c       = bus.adc_valid & (state_q == ST_CAPTURE);
    exit_state = (bus.single_shot || !bus.arm_en) ? ST_IDLE : ST_ARMED;

    case (state_q)
      ST_IDLE: begin
        miss_inc = trig_edge;
        if (bus.arm_en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!bus.arm_en) begin
          miss_inc = trig_edge;
          state_d  = ST_IDLE;
        end else if (trig_edge) begin
          if (bus.capture_len_cfg == 8'd0) begin
            err_d    = 1'b1;
            miss_inc = 1'b1;
          end else begin
            ts_d    = bus.timestamp_counter;
            len_d   = bus.capture_len_cfg;
            cnt_d   = '0;
            fs_d    = 1'b1;
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        miss_inc = trig_edge;
        if (we_c) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        miss_inc = trig_edge;
        if (bus.frame_done) begin
          if (bus.holdoff_cfg != '0) begin
            hold_d  = bus.holdoff_cfg;
            state_d = ST_HOLDOFF;
          end else begin
            state_d = exit_state;
          end
        end
      end
      ST_HOLDOFF: begin
        miss_inc = trig_edge;
        // Counter holds the cycles still to spend here, including this one
        if (hold_q <= HOLDOFF_W'(1)) begin
          hold_d  = '0;
          state_d = exit_state;
        end else begin
          hold_d = hold_q - HOLDOFF_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    miss_d = miss_q;
    if (miss_inc && (miss_q != {MISS_W{1'b1}})) miss_d = miss_q + MISS_W'(1);
  end

  // Write enable stays combinational so it lines up with the ADC data
  assign bus.sample_we       = we_c;
  assign bus.sample_idx      = cnt_q;
  assign bus.frame_start     = fs_q;
  assign bus.frame_ts        = ts_q;
  assign bus.frame_len       = len_q;
  assign bus.busy            = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN) ||
                               (state_q == ST_HOLDOFF);
  assign bus.state_o         = state_q;
  assign bus.missed_trig_cnt = miss_q;
  assign bus.err_len_zero    = err_q;

endmodule

// File: tb/tb_daq_capture_sequencer.sv
// Bench for daq_capture_sequencer: directed scenarios with literal expectations,
// then random traffic, all compared each cycle against a frame-level model.
module tb_daq_capture_sequencer;

  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_DRAIN = 3, S_HOLDOFF = 4;
  localparam int MISS_MAX = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  daq_capture_sequencer_if bus ();

  daq_capture_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: what the outputs must be, tracked as frame progress
  int          m_state   = S_IDLE;
  bit          m_prev    = 1'b0;
  int          m_written = 0;
  int          m_len     = 0;
  logic [31:0] m_ts      = '0;
  int          m_hold    = 0;
  int          m_miss    = 0;
  bit          m_err     = 1'b0;
  bit          m_fs      = 1'b0;

  function automatic void model_reset();
    m_state = S_IDLE; m_prev = 1'b0; m_written = 0; m_len = 0; m_ts = '0;
    m_hold = 0; m_miss = 0; m_err = 1'b0; m_fs = 1'b0;
  endfunction

  function automatic void bump_miss();
    if (m_miss < MISS_MAX) m_miss++;
  endfunction

  function automatic int after_frame();
    return (bus.single_shot || !bus.arm_en) ? S_IDLE : S_ARMED;
  endfunction

  function automatic void model_step();
    bit edge_seen;
    edge_seen = bus.trigger_in && !m_prev;
    m_prev    = bus.trigger_in;
    m_fs      = 1'b0;
    if (m_state == S_ARMED && bus.arm_en && edge_seen) begin
      if (bus.capture_len_cfg == 0) begin
        m_err = 1'b1;
        bump_miss();
      end else begin
        m_ts = bus.timestamp_counter; m_len = int'(bus.capture_len_cfg);
        m_written = 0; m_fs = 1'b1; m_state = S_CAPTURE;
      end
      return;
    end
    if (edge_seen) bump_miss();
    case (m_state)
      S_IDLE:    if (bus.arm_en) m_state = S_ARMED;
      S_ARMED:   if (!bus.arm_en) m_state = S_IDLE;
      S_CAPTURE: if (bus.adc_valid) begin
                   m_written++;
                   if (m_written == m_len) m_state = S_DRAIN;
                 end
      S_DRAIN:   if (bus.frame_done) begin
                   if (bus.holdoff_cfg != 0) begin
                     m_hold = int'(bus.holdoff_cfg); m_state = S_HOLDOFF;
                   end else m_state = after_frame();
                 end
      S_HOLDOFF: begin
                   m_hold--;
                   if (m_hold == 0) m_state = after_frame();
                 end
      default:   m_state = S_IDLE;
    endcase
  endfunction

  always @(posedge clk) if (rst) model_step();

  // Per-cycle comparison away from the active edge
  always @(negedge clk) begin
    bit exp_we;
    if (!rst) model_reset();
    exp_we = bus.adc_valid && (m_state == S_CAPTURE);
    check("state_o", 32'(bus.state_o), 32'(m_state));
    check("busy", 32'(bus.busy), 32'(m_state >= S_CAPTURE));
    check("frame_start", 32'(bus.frame_start), 32'(m_fs));
    check("frame_ts", bus.frame_ts, m_ts);
    check("frame_len", 32'(bus.frame_len), 32'(m_len));
    check("missed_trig_cnt", 32'(bus.missed_trig_cnt), 32'(m_miss));
    check("err_len_zero", 32'(bus.err_len_zero), 32'(m_err));
    check("sample_we", 32'(bus.sample_we), 32'(exp_we));
    if (exp_we) check("sample_idx", 32'(bus.sample_idx), 32'(m_written));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic pulse_trigger();
    bus.trigger_in = 1'b1;
    tick();
    bus.trigger_in = 1'b0;
  endtask

  // Frame of n back-to-back samples ending in frame_done, then count HOLDOFF cycles
  task automatic frame_with_holdoff(input int n, output int hold_cycles);
    pulse_trigger();
    bus.adc_valid = 1'b1;
    repeat (n) tick();
    bus.adc_valid = 1'b0;
    check("drain_reached", 32'(bus.state_o), 32'(S_DRAIN));
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    hold_cycles = 0;
    while (bus.state_o == 3'd4 && hold_cycles < 50) begin
      hold_cycles++;
      tick();
    end
  endtask

  initial begin
    int hc;
    int n;
    int k;
    bus.arm_en = 1'b0; bus.single_shot = 1'b0; bus.trigger_in = 1'b0;
    bus.adc_valid = 1'b0; bus.capture_len_cfg = 8'd0; bus.holdoff_cfg = '0;
    bus.timestamp_counter = '0; bus.frame_done = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_state", 32'(bus.state_o), 32'd0);
    check("rst_missed", 32'(bus.missed_trig_cnt), 32'd0);
    check("rst_err", 32'(bus.err_len_zero), 32'd0);
    check("rst_frame_start", 32'(bus.frame_start), 32'd0);
    rst = 1'b1;

    // Basic frame
    bus.arm_en = 1'b1; bus.capture_len_cfg = 8'd4;
    tick();
    check("armed", 32'(bus.state_o), 32'd1);
    bus.timestamp_counter = 32'h12345678;
    pulse_trigger();
    check("basic_state_cap", 32'(bus.state_o), 32'd2);
    check("basic_frame_start", 32'(bus.frame_start), 32'd1);
    check("basic_frame_ts", bus.frame_ts, 32'h12345678);
    check("basic_frame_len", 32'(bus.frame_len), 32'd4);
    for (int i = 0; i < 4; i++) begin
      bus.adc_valid = 1'b1;
      #1;
      check("basic_we", 32'(bus.sample_we), 32'd1);
      check("basic_idx", 32'(bus.sample_idx), 32'(i));
      tick();
      bus.adc_valid = 1'b0;
      if (i == 0) check("basic_fs_one_cycle", 32'(bus.frame_start), 32'd0);
      tick();
    end
    check("basic_drain", 32'(bus.state_o), 32'd3);
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    check("basic_rearmed", 32'(bus.state_o), 32'd1);

    // Retrigger during frame, then saturation
    bus.timestamp_counter = 32'hCAFE0001;
    pulse_trigger();
    tick();
    repeat (3) begin
      pulse_trigger();
      tick();
    end
    bus.adc_valid = 1'b1;
    repeat (4) tick();
    bus.adc_valid = 1'b0;
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    check("retrig_missed3", 32'(bus.missed_trig_cnt), 32'd3);
    check("retrig_ts", bus.frame_ts, 32'hCAFE0001);
    check("retrig_rearmed", 32'(bus.state_o), 32'd1);
    bus.arm_en = 1'b0;
    tick();
    repeat (300) begin
      pulse_trigger();
      tick();
    end
    check("missed_saturated", 32'(bus.missed_trig_cnt), 32'd255);

    // Holdoff, re-arm then single shot
    do_reset();
    bus.arm_en = 1'b1; bus.holdoff_cfg = 16'd5; bus.capture_len_cfg = 8'd2;
    tick();
    frame_with_holdoff(2, hc);
    check("holdoff_cycles", 32'(hc), 32'd5);
    check("holdoff_to_armed", 32'(bus.state_o), 32'd1);
    bus.single_shot = 1'b1;
    frame_with_holdoff(2, hc);
    check("holdoff_ss_cycles", 32'(hc), 32'd5);
    check("holdoff_ss_idle", 32'(bus.state_o), 32'd0);
    bus.single_shot = 1'b0; bus.holdoff_cfg = '0;

    // Zero length
    do_reset();
    bus.capture_len_cfg = 8'd0;
    tick();
    pulse_trigger();
    check("zl_state", 32'(bus.state_o), 32'd1);
    check("zl_err", 32'(bus.err_len_zero), 32'd1);
    check("zl_no_start", 32'(bus.frame_start), 32'd0);
    check("zl_missed", 32'(bus.missed_trig_cnt), 32'd1);
    tick();

    // Coincident sample and mid-frame config change
    bus.capture_len_cfg = 8'd4;
    bus.trigger_in = 1'b1; bus.adc_valid = 1'b1;
    #1;
    check("coinc_not_written", 32'(bus.sample_we), 32'd0);
    tick();
    bus.trigger_in = 1'b0; bus.capture_len_cfg = 8'd8;
    n = 0; k = 0;
    while (bus.state_o == 3'd2 && k < 40) begin
      if (bus.sample_we) n++;
      k++;
      tick();
    end
    bus.adc_valid = 1'b0;
    check("coinc_samples", 32'(n), 32'd4);
    check("coinc_len_kept", 32'(bus.frame_len), 32'd4);
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    bus.capture_len_cfg = 8'd4;

    // Reset mid-frame
    pulse_trigger();
    bus.adc_valid = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("abort_state", 32'(bus.state_o), 32'd0);
    check("abort_we", 32'(bus.sample_we), 32'd0);
    check("abort_idx", 32'(bus.sample_idx), 32'd0);
    check("abort_len", 32'(bus.frame_len), 32'd0);
    check("abort_ts", bus.frame_ts, 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b1;
    n = 0;
    repeat (6) begin
      if (bus.sample_we || bus.frame_start) n++;
      tick();
    end
    check("abort_quiet", 32'(n), 32'd0);
    bus.adc_valid = 1'b0;

    // arm_en dropped mid-capture completes the frame, then IDLE
    pulse_trigger();
    bus.arm_en = 1'b0; bus.adc_valid = 1'b1;
    repeat (4) tick();
    bus.adc_valid = 1'b0;
    check("disarm_drain", 32'(bus.state_o), 32'd3);
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
    check("disarm_idle", 32'(bus.state_o), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.arm_en      = ($urandom_range(0, 9) != 0);
      bus.single_shot = ($urandom_range(0, 4) == 0);
      bus.trigger_in  = ($urandom_range(0, 2) == 0);
      bus.adc_valid   = $urandom_range(0, 1) == 1;
      bus.frame_done  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) bus.capture_len_cfg = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) bus.holdoff_cfg = 16'($urandom_range(0, 4));
      bus.timestamp_counter = bus.timestamp_counter + 32'd1;
      rst = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
